mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning memory size in 32-bit words (power of two, 4..65536).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning extra cycles inserted before each response (0..15).
REQ-003 SHALL have port clk  input  1  meaning the single clock, rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset: asynchronous, active-high.
REQ-005 SHALL have port request  input  1  meaning the initiator requests a transfer and holds it until valid.
REQ-006 SHALL have port we_re  input  1  meaning 1 = write (store), 0 = read (load).
REQ-007 SHALL have port mask  input  4  meaning byte-lane enables, bit i = byte lane i.
REQ-008 SHALL have port address  input  32  meaning the byte address.
REQ-009 SHALL have port store_data  input  32  meaning the write data, lane-aligned.
REQ-010 SHALL have port load_data  output  32  meaning the read response data.
REQ-011 SHALL have port valid  output  1  meaning a one-cycle response strobe.
REQ-012 SHALL have port err  output  1  meaning an out-of-range access, qualified by valid.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: request=1 at a clock edge SHALL latch we_re, mask, address, store_data; next state WAIT if WAIT_STATES>0, else RESP.
REQ-015 WAIT: SHALL count WAIT_STATES cycles, then go to RESP; request/input changes during WAIT SHALL be ignored.
REQ-016 RESP: valid=1 for exactly one cycle, then IDLE unconditionally.
REQ-017 Latency SHALL be: request accepted at edge k, valid high in cycle k+1+WAIT_STATES.
REQ-018 A request still high in the cycle after valid SHALL be accepted as a new transaction; back-to-back throughput is one transfer per 2+WAIT_STATES cycles.
REQ-019 The word index SHALL be address[log2(DEPTH_WORDS)+1:2]; address[1:0] SHALL be ignored.
REQ-020 A write SHALL update only the lanes with a mask bit set, on the edge entering RESP.
REQ-021 A read SHALL register the full 32-bit word, regardless of mask, on the edge entering RESP; a read immediately following a write to the same word SHALL return the new data.
REQ-022 load_data SHALL hold its last read value through writes and idle cycles.
REQ-023 A write with mask=0 SHALL complete with valid=1 and leave the memory unchanged.
REQ-024 Address bits above the index SHALL be ignored unless MEM_RESP_ERR_EN is defined.

Reset
REQ-025 rst=1 SHALL force IDLE, valid=0, load_data=0, err=0 and the wait counter to 0 asynchronously, including mid-transaction; an in-flight transaction SHALL be dropped.
REQ-026 Memory contents SHALL NOT be cleared by reset.
REQ-027 The first request SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-028 With MEM_RESP_ERR_EN defined: address >= 4*DEPTH_WORDS SHALL suppress the write, return load_data=0, and assert err=1 together with valid.
REQ-029 With MEM_RESP_ERR_EN undefined: err SHALL be tied to 0 and the address SHALL wrap modulo the memory size.

Structure
REQ-030 Package mem_resp_pkg SHALL hold the state enum typedef and the default DEPTH_WORDS/WAIT_STATES constants.
REQ-031 The storage SHALL be a sub-module mem_resp_sram: word array with byte write enables, one synchronous read/write port.

Verification
REQ-032 WAIT_STATES=1: write 0xDEADBEEF, mask=4'hF, addr 0x10 -> valid in the 2nd cycle after acceptance; then read addr 0x10 -> load_data=0xDEADBEEF.
REQ-033 Partial write 0x000000AA, mask=4'b0001, to word holding 0xDEADBEEF -> subsequent read returns 0xDEADBEAA.
REQ-034 WAIT_STATES=0, request held high for 6 cycles -> exactly 3 valid pulses, one every 2 cycles.
REQ-035 rst asserted during WAIT of a write to 0x20 holding 0x0 -> valid never rises, and a later read of 0x20 returns 0x0.
REQ-036 MEM_RESP_ERR_EN, DEPTH_WORDS=1024, write to 0x1000 -> valid=1, err=1, and a read of 0x0 is unchanged; without the macro the same write lands at word 0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and default constants for the mem_responder slice.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned DEFAULT_WAIT_STATES = 1;

endpackage

// File: rtl/mem_resp_sram.sv
// Word-organised storage with per-byte write enables and one synchronous port.
// Only the read-data register is reset; the array itself keeps its contents.
module mem_resp_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Request/response memory target with configurable wait states.
// Define MEM_RESP_ERR_EN to flag out-of-range accesses on err instead of wrapping.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        valid,
  output logic        err
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAST_WAIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic [3:0]        mask_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       data_q;
  logic              oob_q;
  logic              zero_q;

  logic              in_oob;
  logic              fire;
  logic              cur_we;
  logic [3:0]        cur_mask;
  logic [IDX_W-1:0]  cur_idx;
  logic [31:0]       cur_data;
  logic              cur_oob;
  logic [31:0]       sram_rdata;
  logic              unused_addr;

  assign unused_addr = ^address;

`ifdef MEM_RESP_ERR_EN
  assign in_oob = |address[31:IDX_W+2];
`else
  assign in_oob = 1'b0;
`endif

  // With zero wait states the memory access happens on the accepting edge,
  // so the port is fed straight from the inputs while in IDLE.
  always_comb begin
    cur_we   = we_q;
    cur_mask = mask_q;
    cur_idx  = idx_q;
    cur_data = data_q;
    cur_oob  = oob_q;
    if (state == IDLE) begin
      cur_we   = we_re;
      cur_mask = mask;
      cur_idx  = address[IDX_W+1:2];
      cur_data = store_data;
      cur_oob  = in_oob;
    end
  end

  always_comb begin
    fire = 1'b0;
    unique case (state)
      IDLE:    fire = request && (WAIT_STATES == 0);
      WAIT:    fire = (wait_cnt == LAST_WAIT);
      default: fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      mask_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      oob_q    <= 1'b0;
      zero_q   <= 1'b0;
      valid    <= 1'b0;
`ifdef MEM_RESP_ERR_EN
      err      <= 1'b0;
`endif
    end else begin
      valid <= fire;
`ifdef MEM_RESP_ERR_EN
      err   <= fire && cur_oob;
`endif
      // An out-of-range read reports zero until the next in-range read.
      if (fire && !cur_we) zero_q <= cur_oob;
      unique case (state)
        IDLE: begin
          if (request) begin
            we_q     <= we_re;
            mask_q   <= mask;
            idx_q    <= address[IDX_W+1:2];
            data_q   <= store_data;
            oob_q    <= in_oob;
            wait_cnt <= '0;
            state    <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == LAST_WAIT) state <= RESP;
          else                       wait_cnt <= wait_cnt + 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MEM_RESP_ERR_EN
  assign err = 1'b0;
`endif

  assign load_data = zero_q ? '0 : sram_rdata;

  mem_resp_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (IDX_W)
  ) u_sram (
    .clk   (clk),
    .rst   (rst),
    .en    (fire && !cur_oob),
    .we    (cur_we),
    .be    (cur_mask),
    .idx   (cur_idx),
    .wdata (cur_data),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one-wait-state and zero-wait-state instances.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        request = 1'b0;
  logic        we_re = 1'b0;
  logic [3:0]  mask = '0;
  logic [31:0] address = '0;
  logic [31:0] store_data = '0;
  logic [31:0] load_data;
  logic        valid;
  logic        err;

  logic        z_request = 1'b0;
  logic        z_we_re = 1'b0;
  logic [3:0]  z_mask = '0;
  logic [31:0] z_address = '0;
  logic [31:0] z_store_data = '0;
  logic [31:0] z_load_data;
  logic        z_valid;
  logic        z_err;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MEM_RESP_ERR_EN
  localparam logic [31:0] EXP_OOB_ERR = 32'd1;
  localparam logic [31:0] EXP_WORD0   = 32'h1111_1111;
`else
  localparam logic [31:0] EXP_OOB_ERR = 32'd0;
  localparam logic [31:0] EXP_WORD0   = 32'hCAFE_F00D;
`endif

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .request    (request),
    .we_re      (we_re),
    .mask       (mask),
    .address    (address),
    .store_data (store_data),
    .load_data  (load_data),
    .valid      (valid),
    .err        (err)
  );

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_z (
    .clk        (clk),
    .rst        (rst),
    .request    (z_request),
    .we_re      (z_we_re),
    .mask       (z_mask),
    .address    (z_address),
    .store_data (z_store_data),
    .load_data  (z_load_data),
    .valid      (z_valid),
    .err        (z_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // lat = cycle after the accepting edge in which valid was seen (-1 on timeout).
  task automatic xact(input logic w, input logic [3:0] m, input logic [31:0] a,
                      input logic [31:0] d, output int lat,
                      output logic [31:0] rd, output logic e);
    lat = -1;
    rd  = '0;
    e   = 1'b0;
    @(negedge clk);
    request = 1'b1; we_re = w; mask = m; address = a; store_data = d;
    @(posedge clk); #1;
    request = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (valid) begin
        lat = i;
        rd  = load_data;
        e   = err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        e;
    logic        seen;
    int          pulses;
    logic [31:0] pos;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    rst = 1'b0;

    xact(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, lat, rd, e);
    check("wr_latency", lat, 32'd2);
    check("wr_err", {31'd0, e}, 32'd0);
    xact(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, e);
    check("rd_latency", lat, 32'd2);
    check("rd_full_word", rd, 32'hDEAD_BEEF);

    xact(1'b1, 4'b0001, 32'h10, 32'h0000_00AA, lat, rd, e);
    check("hold_after_write", load_data, 32'hDEAD_BEEF);
    xact(1'b0, 4'hF, 32'h10, 32'h0, lat, rd, e);
    check("rd_partial", rd, 32'hDEAD_BEAA);

    xact(1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, lat, rd, e);
    check("mask0_latency", lat, 32'd2);
    xact(1'b0, 4'hF, 32'h13, 32'h0, lat, rd, e);
    check("rd_mask0_lowbits", rd, 32'hDEAD_BEAA);

    xact(1'b1, 4'hF, 32'h20, 32'h0, lat, rd, e);
    check("wr20_latency", lat, 32'd2);
    @(negedge clk);
    request = 1'b1; we_re = 1'b1; mask = 4'hF; address = 32'h20; store_data = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    request = 1'b0;
    rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | valid;
    end
    check("rst_mid_valid", {31'd0, seen}, 32'd0);
    check("rst_mid_load_data", load_data, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    xact(1'b0, 4'hF, 32'h20, 32'h0, lat, rd, e);
    check("post_rst_latency", lat, 32'd2);
    check("rd20_dropped_write", rd, 32'h0);

    xact(1'b1, 4'hF, 32'h0, 32'h1111_1111, lat, rd, e);
    xact(1'b1, 4'hF, 32'h1000, 32'hCAFE_F00D, lat, rd, e);
    check("oob_latency", lat, 32'd2);
    check("oob_err", {31'd0, e}, EXP_OOB_ERR);
    xact(1'b0, 4'hF, 32'h0, 32'h0, lat, rd, e);
    check("rd_word0", rd, EXP_WORD0);
    check("rd_word0_err", {31'd0, e}, 32'd0);
`ifdef MEM_RESP_ERR_EN
    xact(1'b0, 4'hF, 32'h1000, 32'h0, lat, rd, e);
    check("oob_rd_data", rd, 32'h0);
`endif

    @(negedge clk);
    z_request = 1'b1; z_we_re = 1'b1; z_mask = 4'hF;
    z_address = 32'h40; z_store_data = 32'h1234_5678;
    pulses = 0;
    pos = '0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (z_valid) begin
        pulses++;
        pos[i] = 1'b1;
      end
    end
    z_request = 1'b0;
    check("z_pulse_count", pulses, 32'd3);
    check("z_pulse_spacing", pos, 32'h0000_002A);
    @(negedge clk);
    z_request = 1'b1; z_we_re = 1'b0; z_mask = 4'h0; z_address = 32'h40;
    @(posedge clk); #1;
    z_request = 1'b0;
    check("z_rd_valid", {31'd0, z_valid}, 32'd1);
    check("z_rd_data", z_load_data, 32'h1234_5678);
    check("z_err", {31'd0, z_err}, 32'd0);
    @(posedge clk); #1;
    check("z_valid_one_cycle", {31'd0, z_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
